// File: rtl/mul_unit_pkg.sv
// Shared encodings for the iterative multiplier: operation select and FSM states.
// The controller decodes funct3 into these same mulctl constants.
package mul_unit_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,   // low half, signed x signed
        MUL_HSS = 2'b01,   // high half, signed x signed
        MUL_HSU = 2'b10,   // high half, signed x unsigned
        MUL_HUU = 2'b11    // high half, unsigned x unsigned
    } mulctl_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier (RV32M MUL/MULH/MULHSU/MULHU) with magnitude
// capture and a final conditional negate; result valid one cycle on exdone.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mulctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             exdone
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH:0]       b_q, b_d;
    mulctl_e              op_q, op_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 a_signed, b_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH:0]       a_ext, b_ext;
    logic [WIDTH:0]       a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   fixed;

    // Operands are extended by one bit so the most negative value has a magnitude.
    always_comb begin
        a_signed = (mulctl_e'(mulctl) != MUL_HUU);
        b_signed = (mulctl_e'(mulctl) == MUL_LO) || (mulctl_e'(mulctl) == MUL_HSS);
        a_neg    = a_signed & a[WIDTH-1];
        b_neg    = b_signed & b[WIDTH-1];
        a_ext    = {a_neg, a};
        b_ext    = {b_neg, b};
        a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
        b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        sum      = '0;
        fixed    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_mag;
                    b_d     = b_mag;
                    op_d    = mulctl_e'(mulctl);
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = FIX;
                end else begin
                    // Add into the upper half, then shift the whole product right;
                    // the carry lands in the top bit so nothing is lost.
                    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? a_q : '0);
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                fixed    = neg_q ? (~acc_q + 1'b1) : acc_q;
                acc_d    = fixed;
                result_d = (op_q == MUL_LO) ? fixed[WIDTH-1:0] : fixed[2*WIDTH-1:WIDTH];
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= MUL_LO;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != IDLE);
    assign exdone = (state_q == DONE);

endmodule
